// File: rtl/uart_tx.sv
// UART transmitter: start / DBIT data bits (LSB first) / stop on tx.
// Bit timing counts s_tick oversampling pulses from the baud tick generator.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SAMPLE  = 32,
  parameter int SB_TICK = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int SMAX = (SAMPLE > SB_TICK) ? SAMPLE : SB_TICK;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_LAST  = SW'(SAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            tx_reg;

  // Frame sequencer: captures the byte in IDLE, then shifts it out
  // one bit per SAMPLE ticks and holds the line high for SB_TICK ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_reg <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            b      <= din;
            s      <= '0;
            state  <= START;
            tx_reg <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s      <= '0;
              n      <= '0;
              state  <= DATA;
              tx_reg <= b[0];
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
                state  <= STOP;
                tx_reg <= 1'b1;
              end else begin
                n      <= n + 1'b1;
                tx_reg <= b[1];
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == SB_LAST) begin
              state <= IDLE;
              s     <= '0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_done_tick = (state == STOP) & s_tick & (s == SB_LAST);
  assign tx_busy      = (state != IDLE);
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of frames plus
// back-to-back, idle-hold and mid-frame reset sequences.
module tb_uart_tx;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick  = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] din     = 8'h00;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  uart_tx #(.DBIT(8), .SAMPLE(32), .SB_TICK(32)) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .tx_start     (start_a),
    .din          (din),
    .tx_busy      (busy_a),
    .tx_done_tick (done_a),
    .tx           (tx_a)
  );

  uart_tx #(.DBIT(7), .SAMPLE(32), .SB_TICK(64)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .tx_start     (start_b),
    .din          (din[6:0]),
    .tx_busy      (busy_b),
    .tx_done_tick (done_b),
    .tx           (tx_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [7:0]  din;
    int          div;
    int          dbit;
    logic [15:0] wire_exp;
    int          done_exp;
    string       name;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic sa, input logic sb,
                       input logic [7:0] d, input logic st);
    @(negedge clk);
    start_a = sa;
    start_b = sb;
    din     = d;
    s_tick  = st;
    #1;
  endtask

  function automatic logic model_tx(input int rel, input int div,
                                    input int dbit,
                                    input logic [15:0] w);
    int ticks;
    int seg;
    ticks = (rel - 1) / div;
    seg   = ticks / 32;
    if (seg > dbit + 1) seg = dbit + 1;
    return w[seg];
  endfunction

  task automatic run_vec(input vec_t v);
    int   bad_tx, bad_busy, ndone, done_at;
    logic etx, ebusy, otx, obusy, odone;
    bad_tx = 0; bad_busy = 0; ndone = 0; done_at = -1;
    for (int k = 0; k <= v.done_exp + 3; k++) begin
      drive(k == 0 && !v.sel, k == 0 && v.sel, v.din,
            (k % v.div) == 0);
      otx   = v.sel ? tx_b   : tx_a;
      obusy = v.sel ? busy_b : busy_a;
      odone = v.sel ? done_b : done_a;
      if (k == 0 || k > v.done_exp) begin
        etx = 1'b1; ebusy = 1'b0;
      end else begin
        etx = model_tx(k, v.div, v.dbit, v.wire_exp);
        ebusy = 1'b1;
      end
      if (otx !== etx) bad_tx++;
      if (obusy !== ebusy) bad_busy++;
      if (odone === 1'b1) begin
        ndone++;
        done_at = k;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check($sformatf("%s_tx_bad_cycles", v.name), bad_tx, 0);
    check($sformatf("%s_busy_bad_cycles", v.name), bad_busy, 0);
    check($sformatf("%s_done_count", v.name), ndone, 1);
    check($sformatf("%s_done_cycle", v.name), done_at, v.done_exp);
  endtask

  function automatic logic [7:0] fdin(input int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  vec_t vecs[5];
  vec_t v0f;

  initial begin
    int   bad, ndone, bad_done, fs, rel;
    logic etx, ebusy;
    logic [15:0] w;

    vecs[0] = '{0, 8'h55, 1, 8, 16'h02AA, 320,  "f55"};
    vecs[1] = '{0, 8'hA3, 4, 8, 16'h0346, 1280, "fA3_div4"};
    vecs[2] = '{1, 8'h7F, 1, 7, 16'h01FE, 320,  "f7F_d7_sb64"};
    vecs[3] = '{0, 8'h00, 1, 8, 16'h0200, 320,  "f00"};
    vecs[4] = '{0, 8'hFF, 2, 8, 16'h03FE, 640,  "fFF_div2"};
    v0f     = '{0, 8'h0F, 1, 8, 16'h021E, 320,  "post_reset_0F"};

    // reset state with s_tick tied high
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_tx_b", int'(tx_b), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // no request: line must stay idle for 100 clocks
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b0, fdin(k), 1'b1);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) bad++;
    end
    check("idle_hold_bad", bad, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // tx_start held high, din changing: frames at 0, 321, 642
    bad = 0; ndone = 0; bad_done = 0;
    for (int k = 0; k <= 700; k++) begin
      drive(1'b1, 1'b0, fdin(k), 1'b1);
      fs  = (k < 321) ? 0 : (k < 642) ? 321 : 642;
      rel = k - fs;
      w   = {6'b0, 1'b1, fdin(fs), 1'b0};
      if (rel == 0) begin
        etx = 1'b1; ebusy = 1'b0;
      end else begin
        etx = model_tx(rel, 1, 8, w); ebusy = 1'b1;
      end
      if (tx_a !== etx || busy_a !== ebusy) bad++;
      if (done_a === 1'b1) ndone++;
      if ((done_a === 1'b1) != (rel == 320)) bad_done++;
    end
    check("b2b_line_bad", bad, 0);
    check("b2b_done_count", ndone, 2);
    check("b2b_done_place_bad", bad_done, 0);

    // let the third frame finish
    for (int k = 0; k < 330; k++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_drained_busy", int'(busy_a), 0);

    // reset in the middle of data bit 3 of 0xF0
    for (int k = 0; k <= 140; k++)
      drive(k == 0, 1'b0, 8'hF0, 1'b1);
    start_a = 1'b0;
    check("pre_reset_tx", int'(tx_a), 0);
    check("pre_reset_busy", int'(busy_a), 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_tx", int'(tx_a), 1);
    check("async_reset_busy", int'(busy_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(v0f);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
